// File: rtl/rob_pkg.sv
// Shared types and defaults for the ROB memory-side responder.
// Holds the default widths, the response data salt, the per-slot record
// type and the LFSR seed/step used when random latency is enabled
// (ROB_MEM_RAND_LAT_EN).
package rob_pkg;

  localparam int SWIDTH_D    = 4;
  localparam int AWIDTH_D    = 10;
  localparam int DWIDTH_D    = 32;
  localparam int MIN_LAT_D   = 2;
  localparam int LAT_WIDTH_D = 3;
  // Countdown needs room for MIN_LAT + 2^LAT_WIDTH - 1.
  localparam int CNT_W_D     = LAT_WIDTH_D + 2;

  localparam logic [DWIDTH_D-1:0] DATA_SALT_D = 32'hA5A5_0000;
  localparam logic [15:0]         LFSR_SEED   = 16'hACE1;

  typedef struct packed {
    logic                vld;
    logic [AWIDTH_D-1:0] addr;
    logic [CNT_W_D-1:0]  cnt;
  } slot_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/rob_prio_enc.sv
// Lowest-index-set priority encoder.
// Ports: req  - request vector (bit i = candidate i)
//        idx  - index of the lowest set bit (0 when none set)
//        any  - at least one bit set
module rob_prio_enc #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk high to low so the last hit (lowest index) wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_mem_responder.sv
// Memory-side responder for the ROB memory port. Tagged reads are parked in
// a per-ID slot, counted down for MIN_LAT + lat_var cycles, then returned one
// per cycle (lowest ready ID first), so responses come back out of order.
// Returned data is the request address XOR DATA_SALT.
//
// Macro ROB_MEM_RAND_LAT_EN: defined  -> lat_var from a 16-bit LFSR that
//                                        steps on every accepted request
//                            undefined -> lat_var = addr[LAT_WIDTH-1:0]
//
// Ports: clk, rst_ (async, active low)
//        mem_req_val/addr/ID  - read request, always accepted
//        mem_rsp_val/ID/data  - registered response, one-cycle pulse
//        outstanding          - occupied slot count (registered)
//        err_dup_id           - sticky: request landed on a busy slot
module rob_mem_responder
  import rob_pkg::*;
#(
  parameter int SWIDTH    = SWIDTH_D,
  parameter int AWIDTH    = AWIDTH_D,
  parameter int DWIDTH    = DWIDTH_D,
  parameter int MIN_LAT   = MIN_LAT_D,
  parameter int LAT_WIDTH = LAT_WIDTH_D,
  parameter logic [DWIDTH-1:0] DATA_SALT = DWIDTH'(DATA_SALT_D)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              mem_req_val,
  input  logic [AWIDTH-1:0] mem_req_addr,
  input  logic [SWIDTH-1:0] mem_req_ID,
  output logic              mem_rsp_val,
  output logic [SWIDTH-1:0] mem_rsp_ID,
  output logic [DWIDTH-1:0] mem_rsp_data,
  output logic [SWIDTH:0]   outstanding,
  output logic              err_dup_id
);

  localparam int NSLOT = 1 << SWIDTH;
  localparam int CW    = LAT_WIDTH + 2;

  slot_t [NSLOT-1:0] slot_q, slot_d;
  logic              rsp_val_q, rsp_val_d;
  logic [SWIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [SWIDTH:0]   outstanding_q, outstanding_d;
  logic              err_q, err_d;

  logic [NSLOT-1:0]     rdy;
  logic [SWIDTH-1:0]    sel_idx;
  logic                 sel_any;
  logic [LAT_WIDTH-1:0] lat_var;
  logic [CW-1:0]        lat_load;

`ifdef ROB_MEM_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lat_var = lfsr_q[LAT_WIDTH-1:0];
  assign lfsr_d  = mem_req_val ? lfsr_next(lfsr_q) : lfsr_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign lat_var = mem_req_addr[LAT_WIDTH-1:0];
`endif

  assign lat_load = CW'(MIN_LAT) + CW'(lat_var);

  always_comb begin
    for (int i = 0; i < NSLOT; i++) rdy[i] = slot_q[i].vld && (slot_q[i].cnt == '0);
  end

  rob_prio_enc #(.N(NSLOT), .IW(SWIDTH)) u_sel (
    .req (rdy),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_comb begin
    slot_d        = slot_q;
    err_d         = err_q;
    rsp_val_d     = 1'b0;
    rsp_id_d      = '0;
    rsp_data_d    = '0;
    outstanding_d = '0;

    for (int i = 0; i < NSLOT; i++) begin
      if (slot_q[i].vld && (slot_q[i].cnt != '0)) slot_d[i].cnt = slot_q[i].cnt - 1'b1;
    end

    if (sel_any) begin
      slot_d[sel_idx].vld = 1'b0;
      rsp_val_d           = 1'b1;
      rsp_id_d            = sel_idx;
      rsp_data_d          = DWIDTH'(slot_q[sel_idx].addr) ^ DATA_SALT;
    end

    // Applied after the free so a same-cycle re-request of the slot being
    // returned simply re-occupies it and is not a duplicate.
    if (mem_req_val) begin
      if (slot_q[mem_req_ID].vld && !(sel_any && (sel_idx == mem_req_ID))) err_d = 1'b1;
      slot_d[mem_req_ID].vld  = 1'b1;
      slot_d[mem_req_ID].addr = mem_req_addr;
      slot_d[mem_req_ID].cnt  = lat_load;
    end

    for (int i = 0; i < NSLOT; i++) outstanding_d = outstanding_d + (SWIDTH+1)'(slot_d[i].vld);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      slot_q        <= '0;
      rsp_val_q     <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      rsp_val_q     <= rsp_val_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign mem_rsp_val  = rsp_val_q;
  assign mem_rsp_ID   = rsp_id_q;
  assign mem_rsp_data = rsp_data_q;
  assign outstanding  = outstanding_q;
  assign err_dup_id   = err_q;

endmodule
